// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit bridging the core memory port to a req/gnt/rvalid data bus
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  tcnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        access;
    logic        legal;
    logic        aligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [7:0]  tcnt_inc;
    logic        tmo;

    always_comb begin
        access = MemRead | MemWrite;

        legal = 1'b0;
        if (MemRead && !MemWrite)
            legal = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (MemWrite && !MemRead)
            legal = Funct3 inside {3'b000, 3'b001, 3'b010};

        case (Funct3[1:0])
            2'b01:   aligned = ~ALUResult[0];
            2'b10:   aligned = (ALUResult[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        // Stores replicate the datum across lanes so the slave may pick any lane by bus_be.
        case (Funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << ALUResult[1:0];
                wdata_next = {4{WriteData[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << ALUResult[1:0];
                wdata_next = {2{WriteData[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = WriteData;
            end
        endcase
        if (!MemWrite)
            be_next = 4'b1111;

        lane = bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase

        tcnt_inc = tcnt + 8'd1;
        tmo      = (tcnt_inc == TMO_LIMIT);

        Stall = access & (state != DONE) & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tcnt      <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            ReadData  <= 32'd0;
            AccessErr <= 1'b0;
            BusErr    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            AccessErr <= 1'b0;
            BusErr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (legal && aligned) begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_addr  <= {ALUResult[31:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_next;
                            f3_q      <= Funct3;
                            off_q     <= ALUResult[1:0];
                            tcnt      <= 8'd0;
                        end else begin
                            state     <= DONE;
                            AccessErr <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    tcnt <= tcnt_inc;
                    // A grant landing on the final budget cycle still loses to the timeout.
                    if (tmo) begin
                        bus_req <= 1'b0;
                        BusErr  <= 1'b1;
                        state   <= DONE;
                        if (!bus_we)
                            ReadData <= 32'd0;
                    end else if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    tcnt <= tcnt_inc;
                    if (bus_rvalid) begin
                        if (!bus_we)
                            ReadData <= load_val;
                        state <= DONE;
                    end else if (tmo) begin
                        BusErr <= 1'b1;
                        state  <= DONE;
                        if (!bus_we)
                            ReadData <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a randomized bus slave
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, AccessErr, BusErr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr), .BusErr(BusErr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rd; logic aerr; logic berr; int lat; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0, stall_cnt = 0, done_cnt = 0, last_done_cyc = 0, req_start_cyc = 0, req_cycles = 0;
    logic prev_req = 1'b0;

    int gdly = 0, rdly = 0;
    logic [31:0] rdata_cfg = 32'd0;
    int late_req = 0, late_ack = 0;
    int phase = 0, gcnt = 0, rcnt = 0;
    logic [31:0] model_rd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a DONE cycle is the only cycle with an access pending and Stall low.
    always @(negedge clk) begin
        resp_t e;
        cyc++;
        if (bus_req) req_cycles++;
        if (bus_req && !prev_req) req_start_cyc = cyc;
        prev_req = bus_req;
        if (reset) begin
            stall_cnt = 0;
        end else if ((MemRead | MemWrite) && Stall) begin
            stall_cnt++;
        end else if (MemRead | MemWrite) begin
            if (resp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got completion expected none");
            end else begin
                e = resp_q.pop_front();
                check("readdata", ReadData, e.rd);
                check("access_err", 32'(AccessErr), 32'(e.aerr));
                check("bus_err", 32'(BusErr), 32'(e.berr));
                check("latency", stall_cnt + 1, e.lat);
            end
            stall_cnt = 0;
            last_done_cyc = cyc;
            done_cnt++;
        end
        if (reset || !(MemRead | MemWrite) || Stall)
            check("err_outside_done", 32'({AccessErr, BusErr}), 32'd0);
    end

    // Bus slave: grants after gdly REQ cycles, responds rdly cycles after the grant.
    always @(negedge clk) begin
        bus_t b;
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        if (reset) begin
            phase = 0;
            gcnt = 0;
        end else if (late_req != late_ack) begin
            bus_rvalid = 1'b1;
            bus_rdata = 32'hDEAD_BEEF;
            late_ack = late_req;
        end else if (phase == 0) begin
            if (!bus_req) begin
                gcnt = 0;
            end else if (gcnt >= gdly) begin
                bus_gnt = 1'b1;
                phase = 1;
                rcnt = 0;
                gcnt = 0;
                if (bus_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bus_req: got request at %h expected none", bus_addr);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_we", 32'(bus_we), 32'(b.we));
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_be", 32'(bus_be), 32'(b.be));
                    if (b.we) check("bus_wdata", bus_wdata, b.wdata);
                end
            end else begin
                gcnt++;
            end
        end else begin
            if (rcnt >= rdly) begin
                bus_rvalid = 1'b1;
                bus_rdata = rdata_cfg;
                phase = 0;
            end else begin
                rcnt++;
            end
        end
    end

    // Called at a rising edge; returns at the rising edge that follows the DONE cycle.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdat, input int g, input int r);
        resp_t e;
        bus_t b;
        bit ok;
        bit tmo;
        int nb;
        int start;
        logic [31:0] lane;
        logic [63:0] modv, v;
        nb = 1 << f3[1:0];
        ok = (rd != wr) && (rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2))
             && ((addr % nb) == 0);
        tmo = ok && (g + 1 >= TMO);
        e.aerr = !ok;
        e.berr = tmo;
        if (!ok) begin
            e.rd = model_rd;
            e.lat = 2;
        end else begin
            b.we = wr;
            b.addr = addr - (addr % 4);
            b.be = wr ? 4'(((32'd1 << nb) - 1) << (addr % 4)) : 4'hF;
            for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            bus_q.push_back(b);
            lane = rdat >> (8 * (addr % 4));
            modv = 64'd1 << (8 * nb);
            v = {32'd0, lane} % modv;
            if (!f3[2] && nb < 4 && v >= (modv >> 1)) v = v - modv;
            if (tmo) begin
                e.rd = rd ? 32'd0 : model_rd;
                e.lat = TMO + 2;
            end else begin
                e.rd = rd ? v[31:0] : model_rd;
                e.lat = g + r + 4;
            end
        end
        model_rd = e.rd;
        resp_q.push_back(e);
        gdly = g;
        rdly = r;
        rdata_cfg = rdat;
        #1;
        MemRead = rd;
        MemWrite = wr;
        Funct3 = f3;
        ALUResult = addr;
        WriteData = wd;
        start = done_cnt;
        for (int k = 0; k < 300 && done_cnt == start; k++) @(posedge clk);
        if (done_cnt == start) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no DONE expected DONE within 300 cycles");
            resp_q.delete();
        end
        if (tmo) bus_q.delete();
    endtask

    task automatic idle(input int n);
        #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        int sel, g, r, d1;
        reset = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'd0; WriteData = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_bus", {28'd0, bus_req, bus_we, AccessErr, BusErr}, 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_addr_wdata", bus_addr | bus_wdata | 32'(bus_be), 32'd0);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        issue(1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 0, 0);
        issue(1, 0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 0, 0);
        issue(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0, 0);
        req_cycles = 0;
        issue(1, 0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0, 0);
        check("misaligned_no_req", req_cycles, 0);
        issue(1, 0, 3'b011, 32'h0000_3000, 32'd0, 32'd0, 0, 0);
        issue(1, 1, 3'b010, 32'h0000_3000, 32'd0, 32'd0, 0, 0);

        idle(1);
        req_cycles = 0;
        issue(1, 0, 3'b010, 32'h0000_0050, 32'd0, 32'h1234_5678, 255, 0);
        check("timeout_req_cycles", req_cycles, TMO);
        idle(0);
        late_req++;
        repeat (3) @(negedge clk);
        check("late_rvalid_ignored", ReadData, 32'd0);
        @(posedge clk);
        issue(1, 0, 3'b010, 32'h0000_0060, 32'd0, 32'hCAFE_F00D, 0, 0);

        idle(0);
        gdly = 50;
        #1;
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h40;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_in_req_bus_req", 32'(bus_req), 32'd0);
        check("rst_in_req_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_rd = 32'd0;
        @(posedge clk);

        b_push_resp: begin
            bus_t b;
            b.we = 1'b1; b.addr = 32'h44; b.be = 4'hF; b.wdata = 32'h0BAD_F00D;
            bus_q.push_back(b);
        end
        gdly = 0;
        rdly = 20;
        #1;
        MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h44; WriteData = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_in_resp_stall", 32'(Stall), 32'd0);
        check("rst_in_resp_addr", bus_addr, 32'd0);
        @(negedge clk);
        MemWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        issue(0, 1, 3'b010, 32'h0000_0100, 32'h1357_9BDF, 32'd0, 0, 0);
        d1 = last_done_cyc;
        issue(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'h2468_ACE0, 0, 0);
        check("back_to_back_req_gap", req_start_cyc - d1, 2);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (sel >= 6) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            g = $urandom_range(0, 1);
            r = (g == 1) ? 0 : $urandom_range(0, 1);
            issue(sel == 0 || (sel >= 1 && sel <= 5), sel == 0 || sel >= 6, f3,
                  $urandom, $urandom, $urandom, g, r);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        idle(2);
        check("resp_queue_empty", resp_q.size(), 0);
        check("bus_queue_empty", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the single-cycle datapath's memory port. It turns the core's access into a request/grant/response transaction on the data bus:
- address from `ALUResult`, raw store data from `WriteData`, size/sign from `Funct3`;
- byte-lane steering on stores, extraction and sign/zero extension on loads;
- `Stall` held to freeze the PC register until the access completes.

It also flags misaligned or illegal accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: cycles spent in REQ+RESP before the access is aborted with `BusErr`. Range 1..255; the counter is 8-bit.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `MemRead` in 1: current instruction is a load.
- `MemWrite` in 1: current instruction is a store.
- `Funct3` in 3: access size/sign, `Instr[14:12]`.
- `ALUResult` in 32: byte address.
- `WriteData` in 32: store data, right-aligned.
- `ReadData` out 32: extended load result, valid in the DONE cycle, held afterwards.
- `Stall` out 1: combinational; high while an access is in progress.
- `AccessErr` out 1: one-cycle pulse in DONE for a misaligned address, illegal `Funct3`, or `MemRead`&`MemWrite` together.
- `BusErr` out 1: one-cycle pulse in DONE on timeout.
- `bus_req` out 1: request; held until `bus_gnt`.
- `bus_we` out 1: 1 for a store.
- `bus_addr` out 32: word-aligned address, `{ALUResult[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: response (loads and stores); arrives at least 1 cycle after `bus_gnt`.
- `bus_rdata` in 32: load data, valid with `bus_rvalid`.

## Operation
- States: IDLE, REQ, RESP, DONE.
- `access` = `MemRead` | `MemWrite`.

**IDLE**
- On `access` with a legal access: capture address, `bus_be`, `bus_wdata`, `bus_we` and `Funct3`, then go to REQ.
- On `access` with an illegal access: go to DONE with an error flag set and no bus activity.

**Legal `Funct3` values**
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- All other values are illegal.

**Alignment**
- Halfword accesses need `addr[0]`=0.
- Word accesses need `addr[1:0]`=0.

**REQ**
- `bus_req`=1.
- On `bus_gnt`, go to RESP.

**RESP**
- `bus_req`=0.
- On `bus_rvalid`, register `bus_rdata` and go to DONE.

**DONE**
- `Stall`=0 and `ReadData` is updated (loads only; stores leave it unchanged). Error pulses are asserted here.
- Next state is always IDLE, so the next instruction can start the following cycle.

**Stores**
- SB: `bus_wdata`={4{WriteData[7:0]}}, `bus_be`=4'b0001<<addr[1:0].
- SH: `bus_wdata`={2{WriteData[15:0]}}, `bus_be`=4'b0011<<addr[1:0].
- SW: `bus_wdata`=WriteData, `bus_be`=4'b1111.

**Loads**
- The selected lane is `bus_rdata`>>(8·addr[1:0]).
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Loads drive `bus_be`=4'b1111.

**Timeout**
- The counter clears on entry to REQ and increments each cycle in REQ or RESP.
- When it reaches `TIMEOUT`: go to DONE, pulse `BusErr`, drop `bus_req`, set `ReadData`=0 (loads).
- After a timeout, a late `bus_rvalid` arriving in IDLE is ignored.

**`Stall`**
- `Stall` = `access` & (state≠DONE) & ~`reset`.

## Timing
- All bus outputs and `ReadData` come from registers; only `Stall` is combinational.
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-access: immediate IDLE; `bus_req` falls asynchronously. Any outstanding response is ignored.
- Best-case latency (gnt in the first REQ cycle, rvalid one cycle later):
  - cycle 0: IDLE, access detected;
  - cycle 1: REQ;
  - cycle 2: RESP;
  - cycle 3: DONE.
  - `Stall` is high in cycles 0–2, low in cycle 3: a 4-cycle memory instruction.
- Illegal access: cycle 0 IDLE (`Stall`=1), cycle 1 DONE (`AccessErr`=1, `Stall`=0).
- Back-to-back accesses: cycle n DONE, cycle n+1 IDLE accepts the next access.
- `bus_gnt` outside REQ and `bus_rvalid` outside RESP are ignored.
- Inputs must stay stable while `Stall`=1; the core guarantees this by freezing the PC.

## Test plan
- **LB sign-extension:** LB at 0x1003, rdata=0x80FF_FFFF, gnt cycle 1, rvalid cycle 2 -> `ReadData`=0xFFFF_FF80 in cycle 3; `Stall` 1,1,1,0.
- **LHU and SH lane steering:**
  - LHU at 0x2002, rdata=0xBEEF_1234 -> `ReadData`=0x0000_BEEF.
  - SH WriteData=0x0000_ABCD at 0x2002 -> `bus_wdata`=0xABCD_ABCD, `bus_be`=4'b1100, `bus_we`=1.
- **Misaligned LW:** LW at 0x3001 -> no `bus_req`; `AccessErr` pulse in cycle 1.
- **Illegal `Funct3`:** `Funct3`=011 with MemRead -> `AccessErr` pulse in cycle 1.
- **Timeout:** `TIMEOUT`=4, `bus_gnt` never asserted -> `bus_req` high for 4 cycles, then DONE with `BusErr`=1 and `ReadData`=0; a later `bus_rvalid` is ignored.
- **Reset mid-access:** reset asserted in RESP -> `bus_req`/state cleared immediately. Then a back-to-back SW followed by LW, each with `gnt`+1-cycle `rvalid` -> the second access's REQ starts 2 cycles after the first access's DONE.
